motion_update_ctrl: RTL and testbench

Sequences the motion-update phase of the MD engine. It walks every cell's particle list in the current position/velocity bank and streams each live particle through the fully pipelined cell-index/position-update datapath. It then scatters each result (new position plus destination cell) into the opposite bank, maintaining per-cell write pointers. After the last result, it writes a null terminator into every non-full destination cell, pulses `done`, and swaps banks.

---
 rtl/motion_update_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_motion_update_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_update_ctrl.sv
// Motion-update phase sequencer: streams every live particle of the read bank through the
// position-update datapath, scatters results into the write bank, then null-terminates each cell.
module motion_update_ctrl #(
   parameter int NCELL  = 27,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int CELL_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              bank_sel,
   output logic              overflow,
   output logic              rd_en,
   output logic [CELL_W-1:0] rd_cell,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [96:0]       rd_p,
   input  logic [96:0]       rd_v,
   output logic              dp_valid_in,
   output logic [96:0]       dp_p,
   output logic [96:0]       dp_v,
   input  logic              dp_valid_out,
   input  logic [96:0]       dp_newp,
   input  logic [32:0]       dp_cidx,
   output logic              wr_en,
   output logic [CELL_W-1:0] wr_cell,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [96:0]       wr_data
);
   localparam int PTR_W = ADDR_W + 1;
   localparam int OUT_W = $clog2(NCELL * DEPTH + 1);
   localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NCELL - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0]  FULL_PTR  = PTR_W'(DEPTH);
   localparam logic [96:0]       TERM_WORD = {1'b1, 96'b0};

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;
   state_t state;

   logic [PTR_W-1:0]  ptr [NCELL];
   logic [OUT_W-1:0]  outstanding;
   logic [CELL_W-1:0] flush_cell;

   // p1: read response returning this cycle (issued one cycle earlier)
   logic vld_p1;
   logic squash_p1;
   logic tail_p1;

   logic              active;
   logic              null_hit;
   logic              res_live;
   logic              res_in_range;
   logic              res_ok;
   logic              drain_exit;
   logic [CELL_W-1:0] res_cell;
   logic [PTR_W-1:0]  res_ptr;
   logic [CELL_W-1:0] flush_sel;
   logic [PTR_W-1:0]  term_ptr;
   logic              dp_fire_out;

   assign dp_p        = rd_p;
   assign dp_v        = rd_v;
   assign dp_valid_in = vld_p1 & ~squash_p1 & ~rd_p[96];

   assign active      = (state == READ) || (state == DRAIN);
   // A null returning from the last slot of a full cell belongs to a cell already left behind.
   assign null_hit    = (state == READ) & vld_p1 & ~squash_p1 & ~tail_p1 & rd_p[96];
   assign dp_fire_out = active & dp_valid_out;
   assign res_live    = dp_fire_out & ~dp_newp[96] & ~dp_cidx[32];
   assign res_cell    = dp_cidx[CELL_W-1:0];
   assign res_ok      = res_live & res_in_range & (res_ptr != FULL_PTR);
   assign drain_exit  = (state == DRAIN) && !vld_p1 && (outstanding == '0);

   // Stray upper index bits make the destination out of range rather than aliasing a real cell.
   always_comb begin
      res_ptr      = FULL_PTR;
      res_in_range = 1'b0;
      for (int c = 0; c < NCELL; c++) begin
         if (dp_cidx[31:0] == 32'(c)) begin
            res_ptr      = ptr[c];
            res_in_range = 1'b1;
         end
      end
   end

   always_comb begin
      flush_sel = (state == FLUSH) ? flush_cell + 1'b1 : '0;
      term_ptr  = '0;
      for (int c = 0; c < NCELL; c++) begin
         if (flush_sel == CELL_W'(c)) term_ptr = ptr[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         bank_sel    <= 1'b0;
         overflow    <= 1'b0;
         rd_en       <= 1'b0;
         rd_cell     <= '0;
         rd_addr     <= '0;
         vld_p1      <= 1'b0;
         squash_p1   <= 1'b0;
         tail_p1     <= 1'b0;
         outstanding <= '0;
         flush_cell  <= '0;
         wr_en       <= 1'b0;
         wr_cell     <= '0;
         wr_addr     <= '0;
         wr_data     <= '0;
         for (int c = 0; c < NCELL; c++) ptr[c] <= '0;
      end else begin
         done      <= 1'b0;
         vld_p1    <= rd_en;
         squash_p1 <= null_hit;
         tail_p1   <= (rd_addr == LAST_ADDR);

         if (dp_valid_in && !dp_fire_out)
            outstanding <= outstanding + 1'b1;
         else if (!dp_valid_in && dp_fire_out)
            outstanding <= outstanding - 1'b1;

         if (res_live && !res_ok) overflow <= 1'b1;
         for (int c = 0; c < NCELL; c++) begin
            if (res_ok && res_cell == CELL_W'(c)) ptr[c] <= ptr[c] + 1'b1;
         end

         wr_en <= 1'b0;
         if (res_ok) begin
            wr_en   <= 1'b1;
            wr_cell <= res_cell;
            wr_addr <= res_ptr[ADDR_W-1:0];
            wr_data <= dp_newp;
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= READ;
                  busy        <= 1'b1;
                  overflow    <= 1'b0;
                  rd_en       <= 1'b1;
                  rd_cell     <= '0;
                  rd_addr     <= '0;
                  outstanding <= '0;
                  for (int c = 0; c < NCELL; c++) ptr[c] <= '0;
               end
            end
            READ: begin
               if (null_hit || rd_addr == LAST_ADDR) begin
                  rd_addr <= '0;
                  if (rd_cell == LAST_CELL) begin
                     state   <= DRAIN;
                     rd_en   <= 1'b0;
                     rd_cell <= '0;
                  end else begin
                     rd_cell <= rd_cell + 1'b1;
                  end
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_exit) begin
                  state      <= FLUSH;
                  flush_cell <= '0;
                  wr_en      <= (term_ptr != FULL_PTR);
                  wr_cell    <= flush_sel;
                  wr_addr    <= term_ptr[ADDR_W-1:0];
                  wr_data    <= TERM_WORD;
               end
            end
            FLUSH: begin
               if (flush_cell == LAST_CELL) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  bank_sel   <= ~bank_sel;
                  flush_cell <= '0;
               end else begin
                  flush_cell <= flush_sel;
                  wr_en      <= (term_ptr != FULL_PTR);
                  wr_cell    <= flush_sel;
                  wr_addr    <= term_ptr[ADDR_W-1:0];
                  wr_data    <= TERM_WORD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_motion_update_ctrl.sv
// Bench for motion_update_ctrl: banked cell memory, fixed-latency datapath stub and a
// list-level reference model of the phase (per-cell append, overflow, terminators, read cost).
module tb_motion_update_ctrl;
   localparam int NCELL  = 27;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int CELL_W = 5;
   localparam logic [95:0] VMASK = 96'h5A5A_C3C3_0F0F_9696_F00D_1234;
   localparam logic [96:0] TERM  = {1'b1, 96'b0};
   localparam logic [96:0] SENT  = {1'b0, 96'hBAD_BAD_BAD_BAD};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy, done, bank_sel, overflow;
   logic              rd_en;
   logic [CELL_W-1:0] rd_cell;
   logic [ADDR_W-1:0] rd_addr;
   logic [96:0]       rd_p, rd_v;
   logic              dp_valid_in;
   logic [96:0]       dp_p, dp_v;
   logic              dp_valid_out;
   logic [96:0]       dp_newp;
   logic [32:0]       dp_cidx;
   logic              wr_en;
   logic [CELL_W-1:0] wr_cell;
   logic [ADDR_W-1:0] wr_addr;
   logic [96:0]       wr_data;

   motion_update_ctrl #(.NCELL(NCELL), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CELL_W(CELL_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .bank_sel(bank_sel), .overflow(overflow), .rd_en(rd_en), .rd_cell(rd_cell),
      .rd_addr(rd_addr), .rd_p(rd_p), .rd_v(rd_v), .dp_valid_in(dp_valid_in),
      .dp_p(dp_p), .dp_v(dp_v), .dp_valid_out(dp_valid_out), .dp_newp(dp_newp),
      .dp_cidx(dp_cidx), .wr_en(wr_en), .wr_cell(wr_cell), .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   logic [96:0] mem [2][NCELL][DEPTH];
   int          lat = 1;
   int          vecs = 0;
   int          errs = 0;
   bit          exp_bank = 1'b0;

   logic [96:0] exp_mem [NCELL][DEPTH];
   int          exp_len [NCELL];
   int          exp_rd, exp_wr;
   bit          exp_ovf;
   int          rd_cnt, wr_cnt;

   function automatic logic [96:0] vel(input logic [96:0] p);
      return {p[96], p[95:0] ^ VMASK};
   endfunction

   function automatic logic [96:0] upd(input logic [96:0] p, input logic [96:0] v);
      return {p[95], p[95:0] ^ {v[47:0], v[95:48]}};
   endfunction

   // Source bank: one-cycle read latency, velocity derived from the position word
   always @(posedge clk) begin
      if (rd_en && rd_cell < NCELL) begin
         rd_p <= mem[bank_sel][rd_cell][rd_addr];
         rd_v <= vel(mem[bank_sel][rd_cell][rd_addr]);
      end
   end

   // Datapath stub: bit 95 nulls the result, bit 94 nulls the index, bits 36:32 are the destination
   logic        pv [8];
   logic [96:0] pp [8];
   logic [32:0] pc [8];
   always @(posedge clk) begin
      pv[0] <= dp_valid_in;
      pp[0] <= upd(dp_p, dp_v);
      pc[0] <= {dp_p[94], 27'b0, dp_p[36:32]};
      for (int i = 1; i < 8; i++) begin
         pv[i] <= pv[i-1];
         pp[i] <= pp[i-1];
         pc[i] <= pc[i-1];
      end
   end
   assign dp_valid_out = pv[lat-1];
   assign dp_newp      = pp[lat-1];
   assign dp_cidx      = pc[lat-1];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [96:0] rnd97();
      return {1'b0, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [96:0] gen(input int dest, input bit nres, input bit nidx);
      logic [96:0] w;
      w         = rnd97();
      w[95]     = nres;
      w[94]     = nidx;
      w[36:32]  = 5'(dest);
      return w;
   endfunction

   task automatic clear_src();
      for (int c = 0; c < NCELL; c++)
         for (int s = 0; s < DEPTH; s++) begin
            mem[exp_bank][c][s]     = rnd97();
            mem[exp_bank][c][s][96] = 1'b1;
         end
   endtask

   task automatic fill_random();
      int r, n, sel;
      clear_src();
      for (int c = 0; c < NCELL; c++) begin
         r = $urandom_range(0, 9);
         n = (r == 0) ? DEPTH : (r == 1) ? DEPTH - 1 - $urandom_range(0, 1) : $urandom_range(0, 6);
         for (int s = 0; s < n; s++) begin
            sel = $urandom_range(0, 19);
            mem[exp_bank][c][s] = gen((sel == 0) ? $urandom_range(NCELL, 31) : $urandom_range(0, NCELL - 1),
                                      sel == 1, sel == 2);
         end
      end
   endtask

   // Phase as lists: each cell's list runs until a null slot or DEPTH entries; results append
   // in issue order to their destination list.
   task automatic model();
      logic [96:0] p;
      int k, c;
      exp_rd = 0; exp_wr = 0; exp_ovf = 1'b0;
      for (int i = 0; i < NCELL; i++) exp_len[i] = 0;
      for (int i = 0; i < NCELL; i++) begin
         k = 0;
         while (k < DEPTH && !mem[exp_bank][i][k][96]) begin
            p = mem[exp_bank][i][k];
            if (!p[95] && !p[94]) begin
               c = int'(p[36:32]);
               if (c >= NCELL || exp_len[c] == DEPTH) exp_ovf = 1'b1;
               else begin
                  exp_mem[c][exp_len[c]] = upd(p, vel(p));
                  exp_len[c]++;
               end
            end
            k++;
         end
         exp_rd += (k + 2 > DEPTH) ? DEPTH : k + 2;
      end
      for (int i = 0; i < NCELL; i++) exp_wr += exp_len[i] + ((exp_len[i] < DEPTH) ? 1 : 0);
   endtask

   task automatic run_phase(input int l, input bit extra);
      int cyc;
      bit seen;
      bit nb;
      lat = l;
      nb  = ~exp_bank;
      model();
      for (int c = 0; c < NCELL; c++)
         for (int s = 0; s < DEPTH; s++) mem[nb][c][s] = SENT;
      chk("bank_before", bank_sel, exp_bank);
      rd_cnt = 0; wr_cnt = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("ovf_cleared", overflow, 0);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 20000) begin
         if (rd_en) rd_cnt++;
         if (wr_en) begin
            wr_cnt++;
            chk("wr_cell_range", wr_cell < NCELL, 1);
            if (wr_cell < NCELL) mem[nb][wr_cell][wr_addr] = wr_data;
         end
         if (done) seen = 1'b1;
         else begin
            start = extra && (cyc == 3);
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      chk("done_seen", seen, 1);
      if (seen) begin
         chk("busy_at_done", busy, 0);
         chk("bank_toggled", bank_sel, nb);
         chk("overflow", overflow, exp_ovf);
         @(negedge clk);
         chk("done_one_cycle", done, 0);
      end
      chk("read_cycles", rd_cnt, exp_rd);
      chk("write_count", wr_cnt, exp_wr);
      for (int c = 0; c < NCELL; c++) begin
         for (int s = 0; s < exp_len[c]; s++)
            chk($sformatf("data_c%0d_s%0d", c, s), mem[nb][c][s], exp_mem[c][s]);
         if (exp_len[c] < DEPTH)
            chk($sformatf("term_c%0d", c), mem[nb][c][exp_len[c]], TERM);
      end
      exp_bank = nb;
   endtask

   initial begin
      logic [96:0] a;
      bit nb;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {busy, done, bank_sel, overflow, rd_en, dp_valid_in, wr_en}, 0);
      chk("rst_addr", {rd_cell, rd_addr, wr_cell, wr_addr}, 0);
      chk("rst_wdata", wr_data, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // all cells empty
      clear_src();
      run_phase(4, 1'b0);
      chk("empty_reads", rd_cnt, 54);
      chk("empty_writes", wr_cnt, 27);

      // three particles in cell 0 -> 5, 5, 26
      clear_src();
      nb = ~exp_bank;
      a = gen(26, 0, 0);
      mem[exp_bank][0][0] = gen(5, 0, 0);
      mem[exp_bank][0][1] = gen(5, 0, 0);
      mem[exp_bank][0][2] = a;
      run_phase(3, 1'b1);
      chk("three_26_0", mem[nb][26][0], upd(a, vel(a)));
      chk("three_term_5", mem[nb][5][2], TERM);
      chk("three_term_26", mem[nb][26][1], TERM);

      // full cell 3 -> cell 3
      clear_src();
      for (int s = 0; s < DEPTH; s++) mem[exp_bank][3][s] = gen(3, 0, 0);
      run_phase(2, 1'b1);
      chk("full_reads", rd_cnt, 26 * 2 + DEPTH);
      chk("full_writes", wr_cnt, DEPTH + 26);

      // 65 particles over cells 0-1 -> cell 7
      clear_src();
      for (int s = 0; s < DEPTH; s++) mem[exp_bank][0][s] = gen(7, 0, 0);
      mem[exp_bank][1][0] = gen(7, 0, 0);
      run_phase(5, 1'b0);
      chk("ovf_set", overflow, 1);
      chk("ovf_writes", wr_cnt, DEPTH + 26);
      repeat (3) @(negedge clk);
      chk("ovf_sticky", overflow, 1);

      // null results only: dropped silently
      clear_src();
      mem[exp_bank][2][0] = gen(9, 1, 0);
      mem[exp_bank][2][1] = gen(4, 0, 1);
      run_phase(1, 1'b0);
      chk("null_ovf", overflow, 0);
      chk("null_writes", wr_cnt, 27);

      // bad destination index
      clear_src();
      mem[exp_bank][2][0] = gen(27, 0, 0);
      mem[exp_bank][2][1] = gen(9, 0, 0);
      run_phase(6, 1'b0);
      chk("badidx_ovf", overflow, 1);
      chk("badidx_writes", wr_cnt, 28);

      for (int i = 0; i < 3; i++) begin
         fill_random();
         run_phase($urandom_range(1, 7), 1'b1);
      end

      // reset in the middle of READ
      fill_random();
      lat = 3;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {busy, done, bank_sel, overflow, rd_en, dp_valid_in, wr_en}, 0);
      chk("midrst_addr", {rd_cell, rd_addr, wr_cell, wr_addr}, 0);
      chk("midrst_wdata", wr_data, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (12) @(negedge clk);
      exp_bank = 1'b0;
      fill_random();
      run_phase(3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
